picocode_loader: RTL and testbench



---
 rtl/picocode_pkg.sv | 33 +++
 rtl/picocode_loader.sv | 180 ++++++++++++++++++
 tb/tb_picocode_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/picocode_pkg.sv
`timescale 1ns/1ps
// Shared constants, loader FSM encoding and small datapath helpers for the
// picocode program-memory loader.
package picocode_pkg;

  localparam int PROG_ADDR_W = 10;
  localparam int INST_W      = 18;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_LEN_HI = 4'd1;
  localparam logic [3:0] ST_LEN_LO = 4'd2;
  localparam logic [3:0] ST_B0     = 4'd3;
  localparam logic [3:0] ST_B1     = 4'd4;
  localparam logic [3:0] ST_B2     = 4'd5;
  localparam logic [3:0] ST_CHK    = 4'd6;
  localparam logic [3:0] ST_FIN    = 4'd7;
  localparam logic [3:0] ST_ERR    = 4'd8;

  function automatic logic [7:0] chk_update(input logic [7:0] chk,
                                            input logic [7:0] data);
    return chk ^ data;
  endfunction

  // Only the two low bits of B0 reach the instruction word.
  function automatic logic [INST_W-1:0] assemble_word(input logic [1:0] b0,
                                                      input logic [7:0] b1,
                                                      input logic [7:0] b2);
    return {b0, b1, b2};
  endfunction

endpackage

// File: rtl/picocode_loader.sv
`timescale 1ns/1ps
// Framed UART byte stream to program-RAM loader: assembles 18-bit words,
// verifies an XOR checksum and selects RAM or ROM fetch for the CPU.
module picocode_loader
  import picocode_pkg::*;
#(
  parameter logic [7:0] HEADER         = DEFAULT_HEADER,
  parameter int         RST_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   remap,
  output logic                   cpu_reset,
  output logic                   ram_wr_en,
  output logic [PROG_ADDR_W-1:0] ram_address,
  output logic [INST_W-1:0]      ram_data_in,
  output logic                   load_busy,
  output logic                   load_ok,
  output logic                   load_err
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      FIN_LAST   = 8'(RST_CYCLES - 1);

  logic [3:0]             state_r;
  logic [PROG_ADDR_W-1:0] addr_r;
  logic [PROG_ADDR_W-1:0] len_r;
  logic [PROG_ADDR_W-1:0] word_cnt_r;
  logic [7:0]             chk_r;
  logic [1:0]             b0_r;
  logic [7:0]             b1_r;
  logic [TW-1:0]          idle_cnt_r;
  logic [7:0]             fin_cnt_r;
  logic                   timed_s;
  logic                   timeout_s;

  // The idle watchdog only runs while a frame is being received.
  always_comb begin
    timed_s   = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_LEN_HI, ST_LEN_LO, ST_B0, ST_B1, ST_B2, ST_CHK: timed_s = 1'b1;
      default:                                         timed_s = 1'b0;
    endcase
    if (timed_s && !rx_valid && (idle_cnt_r == IDLE_LIMIT)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Frame FSM, word assembly, checksum, RAM write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= {PROG_ADDR_W{1'b0}};
      len_r       <= {PROG_ADDR_W{1'b0}};
      word_cnt_r  <= {PROG_ADDR_W{1'b0}};
      chk_r       <= 8'h00;
      b0_r        <= 2'b00;
      b1_r        <= 8'h00;
      idle_cnt_r  <= {TW{1'b0}};
      fin_cnt_r   <= 8'h00;
      remap       <= 1'b0;
      cpu_reset   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_address <= {PROG_ADDR_W{1'b0}};
      ram_data_in <= {INST_W{1'b0}};
      load_busy   <= 1'b0;
      load_ok     <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      ram_wr_en <= 1'b0;

      if (timed_s && !rx_valid) begin
        idle_cnt_r <= idle_cnt_r + TW'(1);
      end else begin
        idle_cnt_r <= {TW{1'b0}};
      end

      if (timeout_s) begin
        load_err <= 1'b1;
        remap    <= 1'b0;
        state_r  <= ST_ERR;
      end else begin
        case (state_r)
          ST_IDLE: begin
            // Clearing remap here keeps RAM writes out of the fetch path.
            if (rx_valid && (rx_data == HEADER)) begin
              remap      <= 1'b0;
              cpu_reset  <= 1'b1;
              load_busy  <= 1'b1;
              load_ok    <= 1'b0;
              load_err   <= 1'b0;
              addr_r     <= {PROG_ADDR_W{1'b0}};
              chk_r      <= 8'h00;
              word_cnt_r <= {PROG_ADDR_W{1'b0}};
              state_r    <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            if (rx_valid) begin
              len_r[9:8] <= rx_data[1:0];
              state_r    <= ST_LEN_LO;
            end
          end
          ST_LEN_LO: begin
            if (rx_valid) begin
              len_r[7:0] <= rx_data;
              state_r    <= ST_B0;
            end
          end
          ST_B0: begin
            if (rx_valid) begin
              b0_r    <= rx_data[1:0];
              chk_r   <= chk_update(chk_r, rx_data);
              state_r <= ST_B1;
            end
          end
          ST_B1: begin
            if (rx_valid) begin
              b1_r    <= rx_data;
              chk_r   <= chk_update(chk_r, rx_data);
              state_r <= ST_B2;
            end
          end
          ST_B2: begin
            if (rx_valid) begin
              chk_r       <= chk_update(chk_r, rx_data);
              ram_wr_en   <= 1'b1;
              ram_address <= addr_r;
              ram_data_in <= assemble_word(b0_r, b1_r, rx_data);
              addr_r      <= addr_r + 10'd1;
              // len_r holds N-1, so equality marks the last word.
              if (word_cnt_r == len_r) begin
                state_r <= ST_CHK;
              end else begin
                word_cnt_r <= word_cnt_r + 10'd1;
                state_r    <= ST_B0;
              end
            end
          end
          ST_CHK: begin
            if (rx_valid) begin
              if (rx_data == chk_r) begin
                load_ok <= 1'b1;
                remap   <= 1'b1;
              end else begin
                load_err <= 1'b1;
              end
              fin_cnt_r <= 8'h00;
              state_r   <= ST_FIN;
            end
          end
          ST_FIN: begin
            if (fin_cnt_r == FIN_LAST) begin
              cpu_reset <= 1'b0;
              load_busy <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              fin_cnt_r <= fin_cnt_r + 8'd1;
            end
          end
          ST_ERR: begin
            fin_cnt_r <= 8'h00;
            state_r   <= ST_FIN;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_picocode_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for picocode_loader: stimulus queues expected RAM writes
// and end-of-frame status; independent monitors pop and compare them.
module tb_picocode_loader;
  import picocode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        remap, cpu_reset, ram_wr_en, load_busy, load_ok, load_err;
  logic [9:0]  ram_address;
  logic [17:0] ram_data_in;

  typedef struct packed {
    logic [9:0]  addr;
    logic [17:0] data;
  } wr_t;

  typedef struct packed {
    logic ok;
    logic err;
    logic remap;
    logic timed;
  } st_t;

  wr_t wr_q[$];
  st_t st_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_strobe = 0;
  logic busy_prev = 1'b0;

  picocode_loader #(
    .HEADER(8'hA5),
    .RST_CYCLES(16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .remap(remap),
    .cpu_reset(cpu_reset),
    .ram_wr_en(ram_wr_en),
    .ram_address(ram_address),
    .ram_data_in(ram_data_in),
    .load_busy(load_busy),
    .load_ok(load_ok),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (!rst && ram_wr_en) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(ram_address), 32'(e.addr));
        check("wr_data", 32'(ram_data_in), 32'(e.data));
        check("wr_while_remap", 32'(remap), 32'd0);
      end
    end
  end

  // End-of-frame status monitor, triggered by load_busy falling
  always @(negedge clk) begin
    if (!rst && busy_prev && !load_busy) begin
      if (st_q.size() == 0) begin
        check("unexpected_frame_end", 32'd1, 32'd0);
      end else begin
        st_t s;
        s = st_q.pop_front();
        check("load_ok", 32'(load_ok), 32'(s.ok));
        check("load_err", 32'(load_err), 32'(s.err));
        check("remap", 32'(remap), 32'(s.remap));
        check("cpu_reset_released", 32'(cpu_reset), 32'd0);
        if (s.timed) check("fin_cycles", 32'(cyc - last_strobe), 32'd16);
      end
    end
    busy_prev <= load_busy;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    last_strobe = cyc;
  endtask

  task automatic send_word(input logic [17:0] w);
    send_byte({6'b000000, w[17:16]});
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (load_busy && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (load_busy) check({name, "_idle_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_remap"}, 32'(remap), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_ram_wr_en"}, 32'(ram_wr_en), 32'd0);
    check({tag, "_ram_address"}, 32'(ram_address), 32'd0);
    check({tag, "_ram_data_in"}, 32'(ram_data_in), 32'd0);
    check({tag, "_load_busy"}, 32'(load_busy), 32'd0);
    check({tag, "_load_ok"}, 32'(load_ok), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good 2-word frame; checksum 03^12^34^00^AB^CD = 43
    wr_q.push_back('{addr: 10'd0, data: 18'h31234});
    wr_q.push_back('{addr: 10'd1, data: 18'h0ABCD});
    st_q.push_back('{ok: 1'b1, err: 1'b0, remap: 1'b1, timed: 1'b1});
    send_byte(8'hA5);
    check("hdr_cpu_reset", 32'(cpu_reset), 32'd1);
    check("hdr_load_busy", 32'(load_busy), 32'd1);
    send_byte(8'h00); send_byte(8'h01);
    send_word(18'h31234);
    send_word(18'h0ABCD);
    send_byte(8'h43);
    wait_idle("good2");

    // Same frame, wrong checksum
    wr_q.push_back('{addr: 10'd0, data: 18'h31234});
    wr_q.push_back('{addr: 10'd1, data: 18'h0ABCD});
    st_q.push_back('{ok: 1'b0, err: 1'b1, remap: 1'b0, timed: 1'b1});
    send_byte(8'hA5);
    check("bad_hdr_remap", 32'(remap), 32'd0);
    send_byte(8'h00); send_byte(8'h01);
    send_word(18'h31234);
    send_word(18'h0ABCD);
    send_byte(8'h8C);
    wait_idle("bad2");

    // Max frame, word = address; every byte value repeats an even number of times -> chk 00
    for (int i = 0; i < 1024; i++) wr_q.push_back('{addr: 10'(i), data: 18'(i)});
    st_q.push_back('{ok: 1'b1, err: 1'b0, remap: 1'b1, timed: 1'b1});
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'hFF);
    for (int i = 0; i < 1024; i++) send_word(18'(i));
    send_byte(8'h00);
    wait_idle("max");

    // Reload while remap=1, then stall after B1 until the idle timeout
    check("pre_reload_remap", 32'(remap), 32'd1);
    st_q.push_back('{ok: 1'b0, err: 1'b1, remap: 1'b0, timed: 1'b0});
    send_byte(8'hA5);
    check("reload_remap", 32'(remap), 32'd0);
    check("reload_wr_en", 32'(ram_wr_en), 32'd0);
    check("reload_ok_clr", 32'(load_ok), 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h22);
    repeat (99) @(negedge clk);
    check("timeout_early", 32'(load_err), 32'd0);
    @(negedge clk);
    check("timeout_err", 32'(load_err), 32'd1);
    check("timeout_remap", 32'(remap), 32'd0);
    wait_idle("timeout");

    // Reset in B1 of word 5 of an 8-word frame
    for (int k = 0; k < 5; k++) wr_q.push_back('{addr: 10'(k), data: 18'h20000 | 18'(k)});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07);
    for (int k = 0; k < 5; k++) send_word(18'h20000 | 18'(k));
    send_byte(8'h02); send_byte(8'h77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good 1-word frame after reset; checksum 12^34^56 = 70
    wr_q.push_back('{addr: 10'd0, data: 18'h23456});
    st_q.push_back('{ok: 1'b1, err: 1'b0, remap: 1'b1, timed: 1'b1});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    send_byte(8'h70);
    wait_idle("after_rst");

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("st_q_drained", 32'(st_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
